lc3_mem_ctrl: RTL and testbench
===============================

# lc3_mem_ctrl

Two-port memory access controller for the LC-3 datapath. It arbitrates between the instruction-fetch port and the data (LD/ST/LDI/STI) port, and owns the MAR and MDR registers. It sequences each access to the single memory interface, waits on the memory ready (R) signal with a bounded timeout, and returns read data from MDR. It sits between the microsequencer's fetch/data request logic and the memory model.

## Interface
- SIZE, 16, data width (MDR, wdata, rdata)
- ADDR_W, 16, address width (MAR)
- TIMEOUT, 15, max consecutive not-ready ACCESS cycles before error; 0 disables timeout
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch request, level, held until f_done
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch port owns the controller (ACCESS/DONE)
- f_done  out  1  one-cycle pulse, fetch access complete
- d_req  in  1  data request, level, held until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  SIZE  write data
- d_gnt  out  1  data port owns the controller
- d_done  out  1  one-cycle pulse, data access complete
- rdata  out  SIZE  MDR contents; valid with *_done on reads
- err  out  1  one-cycle pulse with *_done when the access timed out
- mem_addr  out  ADDR_W  = MAR
- mem_wdata  out  SIZE  = MDR
- mem_en  out  1  memory enable (MIO.EN), high only in ACCESS
- mem_we  out  1  write strobe, high in ACCESS for writes
- mem_rdata  in  SIZE  memory read data
- mem_ready  in  1  memory ready (R)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req, grant one port. On that edge, load MAR with the port address. For a data write, load MDR with d_wdata. Latch we_q (fetch is always a read). Clear wait counter. Go to ACCESS.
- Arbitration: round-robin, 2-way. With both requesting, grant the port not granted last. Pointer updates on each grant. After reset, "last" = data, so fetch wins the first tie.
- ACCESS: mem_en=1, mem_we=we_q. When mem_ready=1:
  - on reads, MDR <= mem_rdata;
  - go to DONE.
- If mem_ready=0, increment the wait counter. At TIMEOUT consecutive not-ready cycles (TIMEOUT≠0), go to DONE with err_q set. MDR is unchanged.
- DONE: pulse the granted port's done; err = err_q; rdata = MDR. Next state IDLE; clear err_q.
- gnt is high for the granted port in ACCESS and DONE; it is never high for both ports.
- Requester deasserts req in the cycle after its done. A req still high in IDLE is treated as a new request.
- Port inputs are captured only at grant. Later changes to addr/wdata/we, and req drop mid-access, are ignored.
- mem_ready outside ACCESS is ignored.
- Wait counter width is $clog2(TIMEOUT+1), saturating; it does not wrap.

## Timing
- Reset values: state IDLE, MAR=0, MDR=0, we_q=0, err_q=0, wait=0, rr pointer=data. All outputs 0: gnt, done, err, mem_en, mem_we, mem_addr, mem_wdata, rdata.
- Reset mid-access: all of the above apply immediately (async), so mem_en drops without waiting for a clock. No done is issued for the aborted access.
- Minimum latency: req high in cycle 0 (IDLE), ACCESS in cycle 1 with mem_ready=1, done in cycle 2. Earliest next grant is in cycle 3 (IDLE).
- Each extra not-ready cycle adds one cycle of latency.
- Timeout: done+err occurs TIMEOUT+1 cycles after ACCESS entry.
- mem_ready=1 on the cycle the counter reaches TIMEOUT: ready wins, no err.
- All outputs are registered or decoded from state and registers only. There is no combinational path from req or mem_ready to any output.

## Structure
- Package lc3_mem_pkg: state enum (IDLE/ACCESS/DONE), port-id constants (PORT_F=0, PORT_D=1).
- Sub-module lc3_rr_arb2: 2-request round-robin arbiter with grant-enable input and last-grant pointer, reset to favour fetch.
- MAR, MDR, wait counter and FSM live in lc3_mem_ctrl.

## Test plan
- Fetch read, f_addr=16'h3000, mem_rdata=16'h1234, ready in first ACCESS cycle -> f_gnt cycles 1–2, mem_addr=3000, f_done+rdata=1234 in cycle 2, err=0.
- Data write, d_addr=16'h4000, d_wdata=16'hBEEF, ready after 3 not-ready cycles -> mem_en/mem_we high 4 cycles, mem_wdata=BEEF, d_done 1 cycle after ready.
- f_req and d_req both high from reset -> fetch served first, then data. Repeat both high -> strict alternation; gnt never both high.
- TIMEOUT=15, mem_ready held 0 -> done+err pulse 16 cycles after ACCESS entry, MDR unchanged. Same with ready on the 15th wait cycle -> done, no err.
- rst_n low during ACCESS -> mem_en=0 and gnt=0 immediately, no done. After release, a pending f_req is granted normally.
- Change d_addr/d_wdata during ACCESS -> mem_addr/mem_wdata keep the values captured at grant.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access controller.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Wait counter width; kept at least one bit so TIMEOUT=0 still elaborates.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/lc3_rr_arb2.sv
// Two-way round-robin arbiter for fetch (bit 0) and data (bit 1) requests.
// Grant is combinational when enabled; the last-grant pointer resets to data so fetch wins the first tie.
module lc3_rr_arb2
  import lc3_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == PORT_D) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= PORT_D;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: arbitrates fetch/data ports, owns MAR/MDR, sequences one memory access
// at a time with a bounded wait on mem_ready. All outputs decode from registered state.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int SIZE    = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [SIZE-1:0]   d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [SIZE-1:0]   rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SIZE-1:0]   mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [SIZE-1:0]   mem_rdata,
  input  logic              mem_ready
);

  localparam int CW = wait_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [SIZE-1:0]   mdr;
  logic              we_q;
  logic              err_q;
  logic              owner;
  logic [CW-1:0]     wait_cnt;
  logic [1:0]        gnt;
  logic              busy;

  lc3_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({d_req, f_req}),
    .en    (state == ST_IDLE),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mar      <= '0;
      mdr      <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      owner    <= PORT_F;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            state    <= ST_ACCESS;
            owner    <= gnt[1];
            wait_cnt <= '0;
            err_q    <= 1'b0;
            if (gnt[1]) begin
              mar  <= d_addr;
              we_q <= d_we;
              if (d_we) mdr <= d_wdata;
            end else begin
              mar  <= f_addr;
              we_q <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          // Ready is checked before the timeout so a late ready still completes cleanly.
          if (mem_ready) begin
            if (!we_q) mdr <= mem_rdata;
            state <= ST_DONE;
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_V)) begin
            err_q <= 1'b1;
            state <= ST_DONE;
          end else if (wait_cnt != {CW{1'b1}}) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          err_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_ACCESS) || (state == ST_DONE);
  assign f_gnt     = busy && (owner == PORT_F);
  assign d_gnt     = busy && (owner == PORT_D);
  assign f_done    = (state == ST_DONE) && (owner == PORT_F);
  assign d_done    = (state == ST_DONE) && (owner == PORT_D);
  assign err       = (state == ST_DONE) && err_q;
  assign rdata     = mdr;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign mem_en    = (state == ST_ACCESS);
  assign mem_we    = (state == ST_ACCESS) && we_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed vector table, arbitration and reset sequences,
// and randomized transactions scored against a transaction-level model of MDR and latency.
module tb_lc3_mem_ctrl;

  localparam int TO = 15;

  logic        clk;
  logic        rst_n;
  logic        f_req, d_req, d_we;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic        f_gnt, f_done, d_gnt, d_done, err, mem_en, mem_we, mem_ready;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mdr_model;

  lc3_mem_ctrl #(.SIZE(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_done    (f_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_done    (d_done),
    .rdata     (rdata),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdat;
    int          nr;
    int          exp_lat;
    bit          exp_err;
    logic [15:0] exp_rdata;
    int          exp_en;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one request and plays the memory: not ready for nr ACCESS cycles, then ready.
  task automatic run_txn(input bit port, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] mdat, input int nr,
                         input logic [15:0] exp_mw, output int lat, output int en_cnt,
                         output int we_cnt, output bit got_err, output logic [15:0] got_rdata,
                         output bit bad);
    bit done_seen;
    lat = 0; en_cnt = 0; we_cnt = 0; got_err = 0; got_rdata = '0; bad = 0; done_seen = 0;
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    mem_ready = 1'($urandom);
    mem_rdata = 16'($urandom);
    for (int c = 1; c <= 60 && !done_seen; c++) begin
      @(negedge clk);
      if (f_gnt && d_gnt) bad = 1;
      if (err && !(f_done || d_done)) bad = 1;
      if (mem_en) begin
        en_cnt++;
        if (mem_we) we_cnt++;
        if (mem_addr !== addr || mem_wdata !== exp_mw) bad = 1;
        if ((port ? d_gnt : f_gnt) !== 1'b1 || (port ? f_gnt : d_gnt) !== 1'b0) bad = 1;
        mem_ready = (en_cnt > nr);
        mem_rdata = mem_ready ? mdat : 16'($urandom);
        f_addr  = 16'($urandom);
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
        d_we    = 1'($urandom);
      end else begin
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
      end
      if (f_done || d_done) begin
        done_seen = 1;
        lat = c;
        got_err = err;
        got_rdata = rdata;
        if ((port ? d_done : f_done) !== 1'b1 || (port ? f_done : d_done) !== 1'b0) bad = 1;
        f_req = 1'b0;
        d_req = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_and_check(input string name, input bit port, input bit we,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] mdat, input int nr, input int exp_lat,
                               input bit exp_err, input logic [15:0] exp_rdata, input int exp_en);
    int lat, en_cnt, we_cnt;
    bit got_err, bad;
    logic [15:0] got_rdata, exp_mw;
    exp_mw = we ? wdata : mdr_model;
    run_txn(port, we, addr, wdata, mdat, nr, exp_mw, lat, en_cnt, we_cnt, got_err, got_rdata, bad);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_en_cycles"}, en_cnt, exp_en);
    chk({name, "_we_cycles"}, we_cnt, we ? exp_en : 0);
    chk({name, "_err"}, got_err, exp_err);
    chk({name, "_rdata"}, got_rdata, exp_rdata);
    chk({name, "_bus_gnt_ok"}, bad, 0);
    mdr_model = exp_rdata;
  endtask

  vec_t tbl[6];

  initial begin
    int ndone;
    bit both;
    int access, lat_e;
    bit port, we, e_err;
    logic [15:0] addr, wdata, mdat, e_rd;
    int nr;
    int nr_pool[10];

    tbl[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 0,    2,  1'b0, 16'h1234, 1};
    tbl[1] = '{1'b1, 1'b1, 16'h4000, 16'hBEEF, 16'h0000, 3,    5,  1'b0, 16'hBEEF, 4};
    tbl[2] = '{1'b1, 1'b0, 16'h5000, 16'h0000, 16'hDEAD, 1000, 17, 1'b1, 16'hBEEF, 16};
    tbl[3] = '{1'b0, 1'b0, 16'h6000, 16'h0000, 16'hABCD, 15,   17, 1'b0, 16'hABCD, 16};
    tbl[4] = '{1'b1, 1'b0, 16'h7000, 16'h0000, 16'h5555, 14,   16, 1'b0, 16'h5555, 15};
    tbl[5] = '{1'b1, 1'b1, 16'h8000, 16'h0001, 16'hFFFF, 1000, 17, 1'b1, 16'h0001, 16};
    nr_pool = '{0, 0, 1, 2, 3, 7, 14, 15, 16, 40};

    rst_n = 1'b0;
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    f_addr = 16'h0100; d_addr = 16'h0200; d_wdata = 16'h0;
    mem_ready = 1'b1; mem_rdata = 16'h00AA;

    // Reset state with requests pending
    #12;
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_done", {f_done, d_done}, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_en_we", {mem_en, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);

    // Both ports held high from reset: fetch first, then strict alternation every 3 cycles
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    both = 0;
    for (int c = 1; c <= 40 && ndone < 6; c++) begin
      @(negedge clk);
      if (f_gnt && d_gnt) both = 1;
      if (f_done || d_done) begin
        chk($sformatf("tie_port_%0d", ndone), {f_done, d_done}, (ndone % 2) ? 2'b01 : 2'b10);
        chk($sformatf("tie_cycle_%0d", ndone), c, 2 + 3 * ndone);
        ndone++;
      end
      if (ndone == 6) begin
        f_req = 1'b0;
        d_req = 1'b0;
      end
    end
    chk("tie_count", ndone, 6);
    chk("tie_no_dual_gnt", both, 0);
    @(negedge clk);
    mdr_model = 16'h00AA;

    for (int i = 0; i < 6; i++) begin
      run_and_check($sformatf("vec%0d", i), tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                    tbl[i].mdat, tbl[i].nr, tbl[i].exp_lat, tbl[i].exp_err, tbl[i].exp_rdata,
                    tbl[i].exp_en);
    end

    // Randomized transactions against the transaction-level model
    for (int i = 0; i < 40; i++) begin
      port  = 1'($urandom);
      we    = port ? 1'($urandom) : 1'b0;
      addr  = 16'($urandom);
      wdata = 16'($urandom);
      mdat  = 16'($urandom);
      nr    = nr_pool[$urandom_range(0, 9)];
      e_err = (nr > TO);
      access = e_err ? TO + 1 : nr + 1;
      lat_e = access + 1;
      if (we) e_rd = wdata;
      else if (!e_err) e_rd = mdat;
      else e_rd = mdr_model;
      run_and_check($sformatf("rnd%0d", i), port, we, addr, wdata, mdat, nr, lat_e, e_err, e_rd,
                    access);
    end

    // Asynchronous reset in the middle of an access
    f_req = 1'b1;
    f_addr = 16'h1111;
    mem_ready = 1'b0;
    for (int c = 0; c < 10 && !mem_en; c++) @(negedge clk);
    chk("rstmid_reached_access", mem_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_mem_en", mem_en, 0);
    chk("rstmid_gnt", {f_gnt, d_gnt}, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      if (f_done || d_done) ndone++;
    end
    chk("rstmid_no_done", ndone, 0);
    rst_n = 1'b1;
    mdr_model = 16'h0000;
    run_and_check("after_rst", 1'b0, 1'b0, 16'h2222, 16'h0, 16'h7777, 0, 2, 1'b0, 16'h7777, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
